// File: rtl/proc_mem_arbiter.sv
// ============================================================================
// proc_mem_arbiter
//
// Purpose:
//   Merges the processor's instruction-memory (port 0) and data-memory
//   (port 1) val/rdy request streams onto one shared memory port, and routes
//   the in-order memory responses back to the port that issued each request.
//   Requests are arbitrated round-robin. Each accepted request has its
//   opaque[7:0] field replaced by a sequence tag (the tracking FIFO write
//   index). {port_id, original opaque} is remembered in an in-order tracking
//   FIFO so that each response can be steered back with its opaque restored.
//   Both the request path and the response path are purely combinational.
//
// Parameters:
//   p_max_inflight : tracking FIFO depth (max outstanding requests),
//                    power of two, 2..16.
//
// Ports:
//   clk                         : clock, all state updates on the rising edge
//   reset                       : asynchronous, active-low reset
//   imem_reqstream_msg/val/rdy  : port 0 request  (mem_req_4B_t, 77 bits)
//   imem_respstream_msg/val/rdy : port 0 response (mem_resp_4B_t, 47 bits)
//   dmem_reqstream_msg/val/rdy  : port 1 request  (mem_req_4B_t, 77 bits)
//   dmem_respstream_msg/val/rdy : port 1 response (mem_resp_4B_t, 47 bits)
//   mem_reqstream_msg/val/rdy   : merged request towards memory
//   mem_respstream_msg/val/rdy  : in-order response from memory
//
// Message layouts:
//   mem_req_4B_t  : {type[76:74], opaque[73:66], addr[65:34], len[33:32], data[31:0]}
//   mem_resp_4B_t : {type[46:44], opaque[43:36], test[35:34], len[33:32], data[31:0]}
//
// Optional feature (macro PROC_MEM_ARBITER_STATS_EN):
//   When defined, adds three free-running 32-bit statistics outputs:
//     stats_imem_grants : accepted port-0 requests
//     stats_dmem_grants : accepted port-1 requests
//     stats_conflicts   : cycles with both request vals high and a request
//                         accepted
//   When undefined, those ports and counters do not exist.
// ============================================================================
module proc_mem_arbiter #(
   parameter int p_max_inflight = 4
) (
   input  logic        clk,
   input  logic        reset,

   input  logic [76:0] imem_reqstream_msg,
   input  logic        imem_reqstream_val,
   output logic        imem_reqstream_rdy,

   output logic [46:0] imem_respstream_msg,
   output logic        imem_respstream_val,
   input  logic        imem_respstream_rdy,

   input  logic [76:0] dmem_reqstream_msg,
   input  logic        dmem_reqstream_val,
   output logic        dmem_reqstream_rdy,

   output logic [46:0] dmem_respstream_msg,
   output logic        dmem_respstream_val,
   input  logic        dmem_respstream_rdy,

   output logic [76:0] mem_reqstream_msg,
   output logic        mem_reqstream_val,
   input  logic        mem_reqstream_rdy,

   input  logic [46:0] mem_respstream_msg,
   input  logic        mem_respstream_val,
   output logic        mem_respstream_rdy
`ifdef PROC_MEM_ARBITER_STATS_EN
  ,output logic [31:0] stats_imem_grants,
   output logic [31:0] stats_dmem_grants,
   output logic [31:0] stats_conflicts
`endif
);

   localparam int PTR_W = $clog2(p_max_inflight);
   localparam int CNT_W = PTR_W + 1;

   // Opaque field positions inside the request / response messages
   localparam int REQ_OPQ_LSB  = 66;
   localparam int RESP_OPQ_LSB = 36;

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   logic [CNT_W-1:0] count_q,  count_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic             prio_q,   prio_d;     // 0: imem favoured, 1: dmem favoured

   // Tracking FIFO payload; holds only data, so it needs no reset
   logic             fifo_port_q [p_max_inflight];
   logic             fifo_port_d [p_max_inflight];
   logic [7:0]       fifo_opq_q  [p_max_inflight];
   logic [7:0]       fifo_opq_d  [p_max_inflight];

   // -------------------------------------------------------------------------
   // Combinational control
   // -------------------------------------------------------------------------
   logic       full;
   logic       empty;
   logic       both_val;
   logic       any_val;
   logic       grant_dmem;
   logic       push;
   logic       pop;
   logic       stale;
   logic       head_port;
   logic [7:0] head_opq;
   logic [7:0] seq_tag;
   logic [7:0] grant_opq;
   logic [76:0] grant_msg;
   logic [46:0] fwd_msg;

   always_comb begin
      full     = (count_q == CNT_W'(p_max_inflight));
      empty    = (count_q == '0);
      both_val = imem_reqstream_val & dmem_reqstream_val;
      any_val  = imem_reqstream_val | dmem_reqstream_val;

      // Grant depends only on the two vals and prio, never on memory ready,
      // so the merged val/msg cannot flip while memory is stalling.
      grant_dmem = dmem_reqstream_val & (~imem_reqstream_val | prio_q);

      grant_msg = grant_dmem ? dmem_reqstream_msg : imem_reqstream_msg;
      grant_opq = grant_msg[REQ_OPQ_LSB +: 8];

      seq_tag = '0;
      seq_tag[PTR_W-1:0] = wr_ptr_q;
   end

   // -------------------------------------------------------------------------
   // Request path
   // -------------------------------------------------------------------------
   always_comb begin
      mem_reqstream_val  = any_val & ~full;
      mem_reqstream_msg  = grant_msg;
      mem_reqstream_msg[REQ_OPQ_LSB +: 8] = seq_tag;

      imem_reqstream_rdy = imem_reqstream_val & ~grant_dmem & mem_reqstream_rdy & ~full;
      dmem_reqstream_rdy = grant_dmem & mem_reqstream_rdy & ~full;

      push = mem_reqstream_val & mem_reqstream_rdy;
   end

   // -------------------------------------------------------------------------
   // Response path
   // -------------------------------------------------------------------------
   always_comb begin
      head_port = fifo_port_q[rd_ptr_q];
      head_opq  = fifo_opq_q[rd_ptr_q];

      fwd_msg = mem_respstream_msg;
      fwd_msg[RESP_OPQ_LSB +: 8] = head_opq;

      imem_respstream_msg = fwd_msg;
      dmem_respstream_msg = fwd_msg;

      imem_respstream_val = 1'b0;
      dmem_respstream_val = 1'b0;
      mem_respstream_rdy  = 1'b1;   // empty FIFO: drain stale responses

      if (!empty) begin
         imem_respstream_val = mem_respstream_val & ~head_port;
         dmem_respstream_val = mem_respstream_val &  head_port;
         mem_respstream_rdy  = head_port ? dmem_respstream_rdy : imem_respstream_rdy;
      end

      pop   = ~empty & mem_respstream_val & mem_respstream_rdy;
      stale =  empty & mem_respstream_val;
   end

   // -------------------------------------------------------------------------
   // Next state
   // -------------------------------------------------------------------------
   always_comb begin
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
      wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

      // Round-robin only advances when there was an actual contest
      prio_d = prio_q;
      if (push && both_val) begin
         prio_d = ~grant_dmem;
      end

      fifo_port_d = fifo_port_q;
      fifo_opq_d  = fifo_opq_q;
      if (push) begin
         fifo_port_d[wr_ptr_q] = grant_dmem;
         fifo_opq_d[wr_ptr_q]  = grant_opq;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         prio_q   <= 1'b0;
      end else begin
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         prio_q   <= prio_d;
      end
   end

   always_ff @(posedge clk) begin
      fifo_port_q <= fifo_port_d;
      fifo_opq_q  <= fifo_opq_d;
   end

`ifdef PROC_MEM_ARBITER_STATS_EN
   // -------------------------------------------------------------------------
   // Statistics counters (wrap naturally at 2^32)
   // -------------------------------------------------------------------------
   logic [31:0] stats_imem_grants_q, stats_imem_grants_d;
   logic [31:0] stats_dmem_grants_q, stats_dmem_grants_d;
   logic [31:0] stats_conflicts_q,   stats_conflicts_d;

   always_comb begin
      stats_imem_grants_d = stats_imem_grants_q + 32'(push & ~grant_dmem);
      stats_dmem_grants_d = stats_dmem_grants_q + 32'(push &  grant_dmem);
      stats_conflicts_d   = stats_conflicts_q   + 32'(push &  both_val);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stats_imem_grants_q <= '0;
         stats_dmem_grants_q <= '0;
         stats_conflicts_q   <= '0;
      end else begin
         stats_imem_grants_q <= stats_imem_grants_d;
         stats_dmem_grants_q <= stats_dmem_grants_d;
         stats_conflicts_q   <= stats_conflicts_d;
      end
   end

   assign stats_imem_grants = stats_imem_grants_q;
   assign stats_dmem_grants = stats_dmem_grants_q;
   assign stats_conflicts   = stats_conflicts_q;
`endif

`ifndef SYNTHESIS
   // A response with nothing outstanding belongs to a request issued before
   // the last reset; it is swallowed, but worth flagging in simulation.
   always_ff @(posedge clk) begin
      if (reset && stale) begin
         $warning("proc_mem_arbiter: stale memory response dropped (no outstanding request)");
      end
   end
`endif

endmodule

// File: tb/tb_proc_mem_arbiter.sv
// ============================================================================
// tb_proc_mem_arbiter
//
// Self-checking bench for proc_mem_arbiter. Random traffic on both processor
// ports, a random-latency in-order memory, and random response back-pressure
// are checked every cycle against a transaction-level reference model: a
// round-robin priority bit, a queue of outstanding {port, opaque} entries
// and a running tag counter.
// ============================================================================
module tb_proc_mem_arbiter;

   localparam int P = 4;

   logic        clk;
   logic        reset;
   logic [76:0] imem_req_msg;
   logic        imem_req_val;
   logic        imem_req_rdy;
   logic [46:0] imem_resp_msg;
   logic        imem_resp_val;
   logic        imem_resp_rdy;
   logic [76:0] dmem_req_msg;
   logic        dmem_req_val;
   logic        dmem_req_rdy;
   logic [46:0] dmem_resp_msg;
   logic        dmem_resp_val;
   logic        dmem_resp_rdy;
   logic [76:0] mem_req_msg;
   logic        mem_req_val;
   logic        mem_req_rdy;
   logic [46:0] mem_resp_msg;
   logic        mem_resp_val;
   logic        mem_resp_rdy;
`ifdef PROC_MEM_ARBITER_STATS_EN
   logic [31:0] stats_imem_grants;
   logic [31:0] stats_dmem_grants;
   logic [31:0] stats_conflicts;
`endif

   proc_mem_arbiter #(.p_max_inflight(P)) dut (
      .clk                 (clk),
      .reset               (reset),
      .imem_reqstream_msg  (imem_req_msg),
      .imem_reqstream_val  (imem_req_val),
      .imem_reqstream_rdy  (imem_req_rdy),
      .imem_respstream_msg (imem_resp_msg),
      .imem_respstream_val (imem_resp_val),
      .imem_respstream_rdy (imem_resp_rdy),
      .dmem_reqstream_msg  (dmem_req_msg),
      .dmem_reqstream_val  (dmem_req_val),
      .dmem_reqstream_rdy  (dmem_req_rdy),
      .dmem_respstream_msg (dmem_resp_msg),
      .dmem_respstream_val (dmem_resp_val),
      .dmem_respstream_rdy (dmem_resp_rdy),
      .mem_reqstream_msg   (mem_req_msg),
      .mem_reqstream_val   (mem_req_val),
      .mem_reqstream_rdy   (mem_req_rdy),
      .mem_respstream_msg  (mem_resp_msg),
      .mem_respstream_val  (mem_resp_val),
      .mem_respstream_rdy  (mem_resp_rdy)
`ifdef PROC_MEM_ARBITER_STATS_EN
     ,.stats_imem_grants   (stats_imem_grants),
      .stats_dmem_grants   (stats_dmem_grants),
      .stats_conflicts     (stats_conflicts)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // -------------------------------------------------------------------------
   // Reference model state
   // -------------------------------------------------------------------------
   typedef struct {
      bit         port;   // 0 = imem, 1 = dmem
      logic [7:0] opq;
   } trk_t;

   trk_t        track[$];      // requests accepted and not yet answered
   int          next_tag;      // tag the next accepted request will carry
   bit          favour_dmem;   // round-robin: who wins the next contest
   int          mem_pend;      // requests the memory still owes a response
   int unsigned m_igr, m_dgr, m_conf;

   int n_tests;
   int n_fail;

   task automatic chk(input string tag, input logic [76:0] got, input logic [76:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic bit pct(input int p);
      return ($urandom_range(0, 99) < p);
   endfunction

   function automatic logic [76:0] rand_req();
      logic [95:0] t;
      t = {$urandom(), $urandom(), $urandom()};
      return t[76:0];
   endfunction

   function automatic logic [46:0] rand_resp();
      logic [63:0] t;
      t = {$urandom(), $urandom()};
      return t[46:0];
   endfunction

   // One cycle: drive random inputs after the falling edge, check the
   // combinational outputs, then advance the model for the coming rising edge.
   task automatic step(input int p_iv, input int p_dv, input int p_mr,
                       input int p_rv, input int p_ir, input int p_dr);
      bit          full, winner_d, exp_mval, exp_irdy, exp_drdy;
      bit          exp_rrdy, exp_ival, exp_dval, have_head;
      logic [76:0] exp_req;
      logic [46:0] exp_resp;
      trk_t        head;
      trk_t        ent;

      @(negedge clk);
      imem_req_val  = pct(p_iv);
      dmem_req_val  = pct(p_dv);
      imem_req_msg  = rand_req();
      dmem_req_msg  = rand_req();
      mem_req_rdy   = pct(p_mr);
      mem_resp_val  = (mem_pend > 0) && pct(p_rv);
      mem_resp_msg  = rand_resp();
      imem_resp_rdy = pct(p_ir);
      dmem_resp_rdy = pct(p_dr);
      #1;

      // Request side
      full     = (track.size() == P);
      if (imem_req_val && dmem_req_val) winner_d = favour_dmem;
      else                              winner_d = dmem_req_val;
      exp_mval = (imem_req_val || dmem_req_val) && !full;
      exp_irdy = exp_mval && !winner_d && mem_req_rdy;
      exp_drdy = exp_mval &&  winner_d && mem_req_rdy;
      chk("mem_req_val", mem_req_val, exp_mval);
      chk("imem_req_rdy", imem_req_rdy, exp_irdy);
      chk("dmem_req_rdy", dmem_req_rdy, exp_drdy);
      if (exp_mval) begin
         exp_req = winner_d ? dmem_req_msg : imem_req_msg;
         exp_req[73:66] = 8'(next_tag);
         chk("mem_req_msg", mem_req_msg, exp_req);
      end

      // Response side
      have_head = (track.size() != 0);
      exp_ival  = 1'b0;
      exp_dval  = 1'b0;
      exp_rrdy  = 1'b1;
      if (have_head) begin
         head     = track[0];
         exp_ival = mem_resp_val && !head.port;
         exp_dval = mem_resp_val &&  head.port;
         exp_rrdy = head.port ? dmem_resp_rdy : imem_resp_rdy;
      end
      chk("mem_resp_rdy", mem_resp_rdy, exp_rrdy);
      chk("imem_resp_val", imem_resp_val, exp_ival);
      chk("dmem_resp_val", dmem_resp_val, exp_dval);
      if (exp_ival || exp_dval) begin
         exp_resp = mem_resp_msg;
         exp_resp[43:36] = head.opq;
         if (exp_ival) chk("imem_resp_msg", imem_resp_msg, exp_resp);
         else          chk("dmem_resp_msg", dmem_resp_msg, exp_resp);
      end

      // Model update for the coming rising edge
      if (mem_resp_val && exp_rrdy) begin
         mem_pend--;
         if (have_head) void'(track.pop_front());
      end
      if (exp_mval && mem_req_rdy) begin
         ent.port = winner_d;
         ent.opq  = winner_d ? dmem_req_msg[73:66] : imem_req_msg[73:66];
         track.push_back(ent);
         next_tag = (next_tag + 1) % P;
         mem_pend++;
         if (winner_d) m_dgr++; else m_igr++;
         if (imem_req_val && dmem_req_val) begin
            m_conf++;
            favour_dmem = !winner_d;
         end
      end
   endtask

   task automatic run(input int n, input int p_iv, input int p_dv, input int p_mr,
                      input int p_rv, input int p_ir, input int p_dr);
      for (int c = 0; c < n; c++) step(p_iv, p_dv, p_mr, p_rv, p_ir, p_dr);
   endtask

   // Pulse reset low (asynchronously, mid-cycle) and check the idle outputs.
   // Outstanding memory work (mem_pend) survives: those responses become stale.
   task automatic do_reset();
      @(negedge clk);
      imem_req_val  = 1'b0;
      dmem_req_val  = 1'b0;
      mem_resp_val  = 1'b0;
      imem_resp_rdy = 1'b0;
      dmem_resp_rdy = 1'b0;
      mem_req_rdy   = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      track.delete();
      next_tag    = 0;
      favour_dmem = 1'b0;
      m_igr  = 0;
      m_dgr  = 0;
      m_conf = 0;
      chk("rst_mem_req_val", mem_req_val, 1'b0);
      chk("rst_imem_req_rdy", imem_req_rdy, 1'b0);
      chk("rst_dmem_req_rdy", dmem_req_rdy, 1'b0);
      chk("rst_imem_resp_val", imem_resp_val, 1'b0);
      chk("rst_dmem_resp_val", dmem_resp_val, 1'b0);
      chk("rst_mem_resp_rdy", mem_resp_rdy, 1'b1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      n_tests  = 0;
      n_fail   = 0;
      mem_pend = 0;
      reset         = 1'b0;
      imem_req_val  = 1'b0;
      dmem_req_val  = 1'b0;
      imem_req_msg  = '0;
      dmem_req_msg  = '0;
      mem_req_rdy   = 1'b0;
      mem_resp_val  = 1'b0;
      mem_resp_msg  = '0;
      imem_resp_rdy = 1'b0;
      dmem_resp_rdy = 1'b0;

      do_reset();

      // Contested requests right after reset: strict alternation from imem
      run(6,    100, 100, 100, 100, 100, 100);
      run(20,     0,   0, 100, 100, 100, 100);
      // dmem alone with responses stalled: fill to capacity, then release
      run(8,      0, 100, 100,   0, 100, 100);
      run(10,     0, 100, 100, 100, 100, 100);
      // dmem response back-pressure while imem keeps requesting
      run(10,   100,  30, 100,  80,  40,   0);
      run(30,    20,  20, 100, 100, 100, 100);
      // Broad random mix
      run(1500,  60,  60,  70,  60,  70,  70);
      // Leave requests outstanding, reset, let the stale responses drain
      run(10,   100, 100, 100,   0, 100, 100);
      do_reset();
      run(20,     0,   0, 100, 100,  50,  50);
      run(6,    100, 100, 100, 100, 100, 100);
      run(500,   70,  50,  60,  50,  60,  80);
      run(40,     0,   0, 100, 100, 100, 100);

`ifdef PROC_MEM_ARBITER_STATS_EN
      @(negedge clk);
      chk("stats_imem_grants", 77'(stats_imem_grants), 77'(m_igr));
      chk("stats_dmem_grants", 77'(stats_dmem_grants), 77'(m_dgr));
      chk("stats_conflicts",   77'(stats_conflicts),   77'(m_conf));
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/proc_mem_arbiter.md
Name: proc_mem_arbiter

Overview:
- Merges the processor's instruction-memory and data-memory request/response streams onto a single shared memory port.
- Sits directly downstream of the pipelined processor's imem/dmem bypass queues and upstream of the single-ported test memory or cache.
- Arbitrates requests round-robin and tags each accepted request in an in-order tracking FIFO.
- Uses the tag to route each in-order memory response back to the port that issued the request, with that request's original opaque field restored.

Parameters:
- p_max_inflight, 4: depth of the tracking FIFO, i.e. maximum outstanding memory requests; power of two, 2..16.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_reqstream_msg  in  77  mem_req_4B_t from processor imem port (port 0).
- imem_reqstream_val  in  1  request valid.
- imem_reqstream_rdy  out  1  request ready.
- imem_respstream_msg  out  47  mem_resp_4B_t back to imem port.
- imem_respstream_val  out  1  response valid.
- imem_respstream_rdy  in  1  response ready.
- dmem_reqstream_msg/val/rdy  in/in/out  77/1/1  port 1 request; same semantics as port 0.
- dmem_respstream_msg/val/rdy  out/out/in  47/1/1  port 1 response; same semantics as port 0.
- mem_reqstream_msg  out  77  merged request to memory.
- mem_reqstream_val  out  1  merged request valid.
- mem_reqstream_rdy  in  1  memory ready.
- mem_respstream_msg  in  47  response from memory, returned in request order.
- mem_respstream_val  in  1  response valid.
- mem_respstream_rdy  out  1  response ready.

Behaviour:
- Handshakes are val/rdy. A transfer occurs on a cycle with val&rdy high at the rising clk edge.
- Request path is combinational (zero added latency). Response path is combinational.
- The grant decision depends only on the two request vals and the priority pointer, never on mem_reqstream_rdy.
- Grant rules:
  - Only one port valid: that port is granted.
  - Both valid: the port selected by prio is granted.
- Port outputs:
  - mem_reqstream_val = granted port's val & !full.
  - granted port's rdy = mem_reqstream_rdy & !full.
  - Ungranted port's rdy = 0.
- mem_reqstream_msg = granted request with opaque[7:0] replaced by a sequence tag (FIFO write index, zero-extended). All other fields pass through unchanged.
- On an accepted request, push {port_id, original opaque} into the tracking FIFO. If both ports were valid, set prio to the other port. If only one port was valid, prio is unchanged.
- Response routing (FIFO not empty):
  - Head port_id selects the destination port.
  - Destination val = mem_respstream_val.
  - mem_respstream_rdy = destination rdy.
  - Forwarded msg = mem_respstream_msg with opaque restored from the FIFO head.
  - The non-destination port's val = 0.
  - Pop the FIFO on a response transfer.
- FIFO empty while mem_respstream_val is high (stale response):
  - mem_respstream_rdy = 1; the response is consumed and dropped, never forwarded.
  - Simulation builds print a warning.
- Full (count == p_max_inflight): no request is accepted that cycle, even if a response pops in the same cycle. Push and pop in the same cycle are legal whenever count < p_max_inflight.
- Count width is clog2(p_max_inflight)+1. Read/write pointers wrap modulo p_max_inflight.
- Reset values (reset low, asynchronous):
  - count=0, rd_ptr=0, wr_ptr=0, prio=0 (imem favoured).
  - Every val/rdy output low, except mem_respstream_rdy=1 (FIFO empty, so responses are drained).
- Reset asserted mid-operation discards all tracking state. Responses to pre-reset requests that arrive afterward are dropped as stale.
- Port msg outputs are don't-care while the corresponding val is low.

Optional Feature:
- Macro PROC_MEM_ARBITER_STATS_EN.
- Defined: adds three 32-bit output ports.
  - stats_imem_grants: counts accepted port-0 requests.
  - stats_dmem_grants: counts accepted port-1 requests.
  - stats_conflicts: counts cycles with both request vals high and a request accepted.
  - All three reset to 0 and wrap at 2^32.
- Not defined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Single imem read, addr 0x200, opaque 0x5A, memory always ready, one-cycle memory → mem request seen the same cycle with opaque 0x00. Response returns on imem with opaque 0x5A, data intact. dmem val stays 0 throughout.
- Both ports valid every cycle for 6 cycles, mem always ready → grants alternate I,D,I,D,I,D starting with I after reset. Responses route in the same order.
- Memory responses stalled, dmem issues 5 requests with p_max_inflight=4 → 4 accepted with tags 0..3. 5th held (dmem rdy=0) until the first response pops, then accepted the next cycle with tag 0.
- dmem_respstream_rdy held low for 3 cycles while head belongs to dmem, then imem request pending → mem_respstream_rdy=0 for those 3 cycles. Imem requests still accepted while count<4.
- Reset pulsed low mid-stream with 2 requests outstanding, then 2 responses arrive → both dropped (mem_respstream_rdy=1, no port val). count=0 afterward.
- PROC_MEM_ARBITER_STATS_EN defined, run the alternating scenario → stats_imem_grants=3, stats_dmem_grants=3, stats_conflicts=6.
